bus_source_mux: RTL and testbench

//   Parametrised, registered N-source bus multiplexer; successor to the 8-bit 2:1 '157-pair mux.

---
 rtl/bus_source_mux_if.sv | 28 ++
 rtl/bus_source_mux.sv | 139 +++++++++++++
 tb/tb_bus_source_mux.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_source_mux_if.sv
// rtl/bus_source_mux_if.sv - bus and control signals of the N-source bus multiplexer
// master drives sources and control, slave is the multiplexer itself.
interface bus_source_mux_if #(
   parameter int WIDTH = 8,
   parameter int N_SRC = 4
);
   localparam int SEL_W = $clog2(N_SRC);

   logic                   enable_n;
   logic                   mode;
   logic [SEL_W-1:0]       sel;
   logic                   sel_load;
   logic [N_SRC-1:0]       req;
   logic [N_SRC*WIDTH-1:0] data_in;
   logic [WIDTH-1:0]       y;
   logic                   y_valid;
   logic [N_SRC-1:0]       grant;

   modport master (
      output enable_n, mode, sel, sel_load, req, data_in,
      input  y, y_valid, grant
   );

   modport slave (
      input  enable_n, mode, sel, sel_load, req, data_in,
      output y, y_valid, grant
   );
endinterface

// File: rtl/bus_source_mux.sv
// rtl/bus_source_mux.sv - registered N-source bus mux with direct select and round-robin modes
// Owner is cur_sel in direct mode, or the granted source while the arbiter is OWNED.
module bus_source_mux #(
   parameter int WIDTH = 8,
   parameter int N_SRC = 4
) (
   input  logic             clk,
   input  logic             rst,
   bus_source_mux_if.slave  bus
);
   localparam int SEL_W = $clog2(N_SRC);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OWNED = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             mode_q;
   logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [SEL_W-1:0] owner_q, owner_d;
   logic [N_SRC-1:0] grant_q, grant_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             y_valid_q, y_valid_d;

   logic             mode_chg;
   logic             sel_ok;
   logic             own_req;
   logic             owner_vld;
   logic [SEL_W-1:0] owner_idx;
   logic [SEL_W-1:0] rr_next;
   logic [WIDTH-1:0] src_data;
   logic             hi_found;
   logic [SEL_W-1:0] hi_idx, lo_idx, pick;

   function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_SRC-1:0] v;
      v = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (idx == SEL_W'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Lowest requester at or above rr_ptr, otherwise lowest requester overall (wrap).
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            lo_idx = SEL_W'(i);
            if (SEL_W'(i) >= rr_ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = SEL_W'(i);
            end
         end
      end
      pick = hi_found ? hi_idx : lo_idx;
   end

   assign mode_chg  = (bus.mode != mode_q);
   assign sel_ok    = ({1'b0, bus.sel} < (SEL_W + 1)'(N_SRC));
   assign own_req   = |(bus.req & grant_q);
   assign rr_next   = (owner_q == SEL_W'(N_SRC - 1)) ? '0 : owner_q + SEL_W'(1);
   assign owner_vld = !mode_q || (state_q == ST_OWNED);
   assign owner_idx = mode_q ? owner_q : cur_sel_q;

   always_comb begin
      src_data = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (owner_idx == SEL_W'(i)) src_data = bus.data_in[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_sel_d = cur_sel_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      grant_d   = grant_q;

      if (mode_chg) begin
         // The new mode is honoured only from the following edge.
         state_d = ST_IDLE;
         grant_d = '0;
      end else if (!bus.mode) begin
         state_d = ST_IDLE;
         grant_d = onehot(cur_sel_q);
         if (bus.sel_load && sel_ok) cur_sel_d = bus.sel;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|bus.req) begin
                  owner_d = pick;
                  grant_d = onehot(pick);
                  state_d = ST_OWNED;
               end else begin
                  grant_d = '0;
               end
            end
            default: begin
               if (!own_req) begin
                  grant_d  = '0;
                  rr_ptr_d = rr_next;
                  state_d  = ST_IDLE;
               end
            end
         endcase
      end
   end

   assign y_valid_d = !bus.enable_n && owner_vld;
   assign y_d       = y_valid_d ? src_data : '0;

   always_ff @(posedge clk) begin
      mode_q <= bus.mode;
      if (rst) begin
         state_q   <= ST_IDLE;
         cur_sel_q <= '0;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         grant_q   <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_sel_q <= cur_sel_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         grant_q   <= grant_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign bus.y       = y_q;
   assign bus.y_valid = y_valid_q;
   assign bus.grant   = grant_q;
endmodule

// File: tb/tb_bus_source_mux.sv
// tb/tb_bus_source_mux.sv - scoreboard bench for bus_source_mux (N_SRC=4 and N_SRC=3 instances)
module tb_bus_source_mux;
   // ctl = {rst, mode, sel_load, enable_n}
   typedef struct packed {
      logic [3:0] ctl;
      logic [1:0] sel;
      logic [3:0] req;
      logic [3:0] g;
      logic [7:0] y;
      logic       yv;
   } step_t;

   logic clk = 1'b0;
   logic rst;
   logic rst3;

   bus_source_mux_if #(.WIDTH(8), .N_SRC(4)) bus4 ();
   bus_source_mux_if #(.WIDTH(8), .N_SRC(3)) bus3 ();

   bus_source_mux #(.WIDTH(8), .N_SRC(4)) dut4 (.clk(clk), .rst(rst),  .bus(bus4));
   bus_source_mux #(.WIDTH(8), .N_SRC(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

   step_t sb[$];
   int    errors = 0;
   int    checks = 0;

   always #5 clk = ~clk;

   function automatic step_t mk(input logic [3:0] ctl, input logic [1:0] sel,
                                input logic [3:0] req, input logic [3:0] g,
                                input logic [7:0] yy, input logic yv);
      step_t s;
      s.ctl = ctl;
      s.sel = sel;
      s.req = req;
      s.g   = g;
      s.y   = yy;
      s.yv  = yv;
      return s;
   endfunction

   task automatic drive4(input step_t s);
      rst            = s.ctl[3];
      bus4.mode      = s.ctl[2];
      bus4.sel_load  = s.ctl[1];
      bus4.enable_n  = s.ctl[0];
      bus4.sel       = s.sel;
      bus4.req       = s.req;
      sb.push_back(s);
   endtask

   task automatic drive3(input step_t s);
      rst3           = s.ctl[3];
      bus3.mode      = s.ctl[2];
      bus3.sel_load  = s.ctl[1];
      bus3.enable_n  = s.ctl[0];
      bus3.sel       = s.sel;
      bus3.req       = s.req[2:0];
      sb.push_back(s);
   endtask

   task automatic test_reset();
      step_t t[$];
      step_t e;
      t.push_back(mk(4'b1010, 2'd3, 4'hF, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b1010, 2'd3, 4'hF, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b0000, 2'd0, 4'h0, 4'h1, 8'h11, 1'b1));
      foreach (t[i]) begin
         drive4(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus4.grant !== e.g) begin errors++; $display("FAIL reset[%0d] grant got=%b exp=%b", i, bus4.grant, e.g); end
         checks++;
         if (bus4.y !== e.y) begin errors++; $display("FAIL reset[%0d] y got=%h exp=%h", i, bus4.y, e.y); end
         checks++;
         if (bus4.y_valid !== e.yv) begin errors++; $display("FAIL reset[%0d] y_valid got=%b exp=%b", i, bus4.y_valid, e.yv); end
      end
   endtask

   task automatic test_direct();
      step_t t[$];
      step_t e;
      t.push_back(mk(4'b1000, 2'd0, 4'h0, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b0010, 2'd2, 4'h0, 4'h1, 8'h11, 1'b1));
      t.push_back(mk(4'b0000, 2'd2, 4'h0, 4'h4, 8'h33, 1'b1));
      t.push_back(mk(4'b0010, 2'd3, 4'h0, 4'h4, 8'h33, 1'b1));
      t.push_back(mk(4'b0001, 2'd3, 4'h0, 4'h8, 8'h00, 1'b0));
      t.push_back(mk(4'b0001, 2'd3, 4'h0, 4'h8, 8'h00, 1'b0));
      t.push_back(mk(4'b0000, 2'd3, 4'h0, 4'h8, 8'h44, 1'b1));
      foreach (t[i]) begin
         drive4(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus4.grant !== e.g) begin errors++; $display("FAIL direct[%0d] grant got=%b exp=%b", i, bus4.grant, e.g); end
         checks++;
         if (bus4.y !== e.y) begin errors++; $display("FAIL direct[%0d] y got=%h exp=%h", i, bus4.y, e.y); end
         checks++;
         if (bus4.y_valid !== e.yv) begin errors++; $display("FAIL direct[%0d] y_valid got=%b exp=%b", i, bus4.y_valid, e.yv); end
      end
   endtask

   task automatic test_rr_basic();
      step_t t[$];
      step_t e;
      t.push_back(mk(4'b1100, 2'd0, 4'b1010, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b1010, 4'b0010, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b1010, 4'b0010, 8'h22, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'b1000, 4'b0000, 8'h22, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'b1000, 4'b1000, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b1000, 4'b1000, 8'h44, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'b0110, 4'b0000, 8'h44, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'b0110, 4'b0010, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b0110, 4'b0010, 8'h22, 1'b1));
      foreach (t[i]) begin
         drive4(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus4.grant !== e.g) begin errors++; $display("FAIL rr_basic[%0d] grant got=%b exp=%b", i, bus4.grant, e.g); end
         checks++;
         if (bus4.y !== e.y) begin errors++; $display("FAIL rr_basic[%0d] y got=%h exp=%h", i, bus4.y, e.y); end
         checks++;
         if (bus4.y_valid !== e.yv) begin errors++; $display("FAIL rr_basic[%0d] y_valid got=%b exp=%b", i, bus4.y_valid, e.yv); end
      end
   endtask

   task automatic test_rr_hold();
      step_t t[$];
      step_t e;
      t.push_back(mk(4'b1100, 2'd0, 4'hF, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'hF, 4'h1, 8'h00, 1'b0));
      for (int k = 0; k < 9; k++) t.push_back(mk(4'b0100, 2'd0, 4'hF, 4'h1, 8'h11, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'b1110, 4'h0, 8'h11, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'hF,    4'h2, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b1101, 4'h0, 8'h22, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'hF,    4'h4, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b1011, 4'h0, 8'h33, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'hF,    4'h8, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b0111, 4'h0, 8'h44, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'hF,    4'h1, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'hF,    4'h1, 8'h11, 1'b1));
      foreach (t[i]) begin
         drive4(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus4.grant !== e.g) begin errors++; $display("FAIL rr_hold[%0d] grant got=%b exp=%b", i, bus4.grant, e.g); end
         checks++;
         if (bus4.y !== e.y) begin errors++; $display("FAIL rr_hold[%0d] y got=%h exp=%h", i, bus4.y, e.y); end
         checks++;
         if (bus4.y_valid !== e.yv) begin errors++; $display("FAIL rr_hold[%0d] y_valid got=%b exp=%b", i, bus4.y_valid, e.yv); end
      end
   endtask

   task automatic test_mode_switch();
      step_t t[$];
      step_t e;
      t.push_back(mk(4'b1000, 2'd0, 4'h0, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b0010, 2'd1, 4'h0, 4'h1, 8'h11, 1'b1));
      t.push_back(mk(4'b0100, 2'd1, 4'h4, 4'h0, 8'h22, 1'b1));
      t.push_back(mk(4'b0100, 2'd1, 4'h4, 4'h4, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd1, 4'h4, 4'h4, 8'h33, 1'b1));
      t.push_back(mk(4'b0000, 2'd1, 4'h4, 4'h0, 8'h33, 1'b1));
      t.push_back(mk(4'b0000, 2'd1, 4'h4, 4'h2, 8'h22, 1'b1));
      t.push_back(mk(4'b0000, 2'd1, 4'h4, 4'h2, 8'h22, 1'b1));
      foreach (t[i]) begin
         drive4(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus4.grant !== e.g) begin errors++; $display("FAIL mode_switch[%0d] grant got=%b exp=%b", i, bus4.grant, e.g); end
         checks++;
         if (bus4.y !== e.y) begin errors++; $display("FAIL mode_switch[%0d] y got=%h exp=%h", i, bus4.y, e.y); end
         checks++;
         if (bus4.y_valid !== e.yv) begin errors++; $display("FAIL mode_switch[%0d] y_valid got=%b exp=%b", i, bus4.y_valid, e.yv); end
      end
   endtask

   task automatic test_reset_mid();
      step_t t[$];
      step_t e;
      t.push_back(mk(4'b1100, 2'd0, 4'b0000, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b0010, 4'h2, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b0000, 4'h0, 8'h22, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'b0100, 4'h4, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b0100, 4'h4, 8'h33, 1'b1));
      t.push_back(mk(4'b1100, 2'd0, 4'b0100, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b0100, 4'h4, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b0000, 4'h0, 8'h33, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'b0100, 4'h4, 8'h00, 1'b0));
      t.push_back(mk(4'b1100, 2'd0, 4'b0100, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b1100, 4'h4, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'b1100, 4'h4, 8'h33, 1'b1));
      foreach (t[i]) begin
         drive4(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus4.grant !== e.g) begin errors++; $display("FAIL reset_mid[%0d] grant got=%b exp=%b", i, bus4.grant, e.g); end
         checks++;
         if (bus4.y !== e.y) begin errors++; $display("FAIL reset_mid[%0d] y got=%h exp=%h", i, bus4.y, e.y); end
         checks++;
         if (bus4.y_valid !== e.yv) begin errors++; $display("FAIL reset_mid[%0d] y_valid got=%b exp=%b", i, bus4.y_valid, e.yv); end
      end
   endtask

   task automatic test_n3();
      step_t t[$];
      step_t e;
      t.push_back(mk(4'b1000, 2'd0, 4'h0, 4'h0, 8'h00, 1'b0));
      t.push_back(mk(4'b0010, 2'd2, 4'h0, 4'h1, 8'hA1, 1'b1));
      t.push_back(mk(4'b0010, 2'd3, 4'h0, 4'h4, 8'hC3, 1'b1));
      t.push_back(mk(4'b0000, 2'd3, 4'h0, 4'h4, 8'hC3, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'h4, 4'h0, 8'hC3, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'h4, 4'h4, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'h1, 4'h0, 8'hC3, 1'b1));
      t.push_back(mk(4'b0100, 2'd0, 4'h3, 4'h1, 8'h00, 1'b0));
      t.push_back(mk(4'b0100, 2'd0, 4'h3, 4'h1, 8'hA1, 1'b1));
      foreach (t[i]) begin
         drive3(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (bus3.grant !== e.g[2:0]) begin errors++; $display("FAIL n3[%0d] grant got=%b exp=%b", i, bus3.grant, e.g[2:0]); end
         checks++;
         if (bus3.y !== e.y) begin errors++; $display("FAIL n3[%0d] y got=%h exp=%h", i, bus3.y, e.y); end
         checks++;
         if (bus3.y_valid !== e.yv) begin errors++; $display("FAIL n3[%0d] y_valid got=%b exp=%b", i, bus3.y_valid, e.yv); end
      end
   endtask

   initial begin
      rst           = 1'b1;
      rst3          = 1'b1;
      bus4.mode     = 1'b0;
      bus4.sel      = 2'd0;
      bus4.sel_load = 1'b0;
      bus4.enable_n = 1'b0;
      bus4.req      = 4'h0;
      bus4.data_in  = 32'h44332211;
      bus3.mode     = 1'b0;
      bus3.sel      = 2'd0;
      bus3.sel_load = 1'b0;
      bus3.enable_n = 1'b0;
      bus3.req      = 3'h0;
      bus3.data_in  = 24'hC3B2A1;

      test_reset();
      test_direct();
      test_rr_basic();
      test_rr_hold();
      test_mode_switch();
      test_reset_mid();
      test_n3();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
